// File: rtl/decode_ctrl.sv
// Decode-stage sequencer: buffers fetched instructions, feeds the FIFO head to the decoder,
// and registers the resulting uop behind a valid/ready handshake.
module decode_ctrl #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned UOP_WIDTH   = 60,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  output logic                          fetch_ready_o,
  input  logic [INSTR_WIDTH-1:0]        fetch_instr_i,
  input  logic [PC_WIDTH-1:0]           fetch_pc_i,
  output logic [INSTR_WIDTH-1:0]        dec_instr_o,
  output logic [PC_WIDTH-1:0]           dec_pc_o,
  input  logic                          dec_nop_i,
  input  logic                          dec_invalid_i,
  input  logic [UOP_WIDTH-1:0]          dec_uop_i,
  output logic                          uop_valid_o,
  input  logic                          uop_ready_i,
  output logic [UOP_WIDTH-1:0]          uop_out_o,
  output logic                          illegal_valid_o,
  output logic [PC_WIDTH-1:0]           illegal_pc_o,
  output logic                          nop_drop_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   uop_valid_q, uop_valid_d;
  logic [UOP_WIDTH-1:0]   uop_q, uop_d;
  logic                   ill_valid_q, ill_valid_d;
  logic [PC_WIDTH-1:0]    ill_pc_q, ill_pc_d;
  logic                   nop_drop_q, nop_drop_d;

  logic [INSTR_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem_q    [FIFO_DEPTH];

  logic push, consume;

  // Ready depends on registered occupancy only; a same-cycle pop does not open a slot.
  assign fetch_ready_o = (count_q < DepthCnt) && !flush_i;
  assign push          = fetch_valid_i && fetch_ready_o;
  assign consume       = (state_q == StRun) && (count_q != '0) && (!uop_valid_q || uop_ready_i);

  assign dec_instr_o = instr_mem_q[rptr_q];
  assign dec_pc_o    = pc_mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wptr_q] <= fetch_instr_i;
      pc_mem_q[wptr_q]    <= fetch_pc_i;
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    state_d     = state_q;
    uop_valid_d = uop_valid_q;
    uop_d       = uop_q;
    ill_valid_d = 1'b0;
    ill_pc_d    = ill_pc_q;
    nop_drop_d  = 1'b0;

    if (flush_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      uop_valid_d = 1'b0;
      state_d     = StRun;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrOne;
      end
      if (consume) begin
        rptr_d = rptr_q + PtrOne;
      end
      count_d = count_q + CntW'(push) - CntW'(consume);

      if (uop_valid_q && uop_ready_i) begin
        uop_valid_d = 1'b0;
      end

      if (consume) begin
        if (dec_invalid_i) begin
          ill_valid_d = 1'b1;
          ill_pc_d    = pc_mem_q[rptr_q];
          state_d     = StHalt;
        end else if (dec_nop_i) begin
          nop_drop_d = 1'b1;
        end else begin
          uop_d       = dec_uop_i;
          uop_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      uop_valid_q <= 1'b0;
      uop_q       <= '0;
      ill_valid_q <= 1'b0;
      ill_pc_q    <= '0;
      nop_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      uop_valid_q <= uop_valid_d;
      uop_q       <= uop_d;
      ill_valid_q <= ill_valid_d;
      ill_pc_q    <= ill_pc_d;
      nop_drop_q  <= nop_drop_d;
    end
  end

  assign uop_valid_o     = uop_valid_q;
  assign uop_out_o       = uop_q;
  assign illegal_valid_o = ill_valid_q;
  assign illegal_pc_o    = ill_pc_q;
  assign nop_drop_o      = nop_drop_q;
  assign fifo_count_o    = count_q;

  // Occupancy must stay within the buffer.
  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DepthCnt)
    else $error("decode_ctrl: fifo_count overflow %0d", count_q);

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl with a stub decoder and a uop scoreboard.
module tb_decode_ctrl;

  localparam logic [31:0] Add  = 32'h003100B3;
  localparam logic [31:0] Nop  = 32'h00000013;
  localparam logic [31:0] Ill  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_nop;
  logic        dec_invalid;
  logic [59:0] dec_uop;
  logic        uop_valid;
  logic        uop_ready;
  logic [59:0] uop_out;
  logic        illegal_valid;
  logic [31:0] illegal_pc;
  logic        nop_drop;
  logic [2:0]  fifo_count;

  int passed = 0;
  int total  = 0;
  int uop_cnt = 0;
  int nop_cnt = 0;
  int ill_cnt = 0;
  logic [31:0] ill_pc_seen = '0;
  logic [59:0] expq [$];

  always #5 clk = ~clk;

  decode_ctrl #(
    .INSTR_WIDTH(32),
    .PC_WIDTH   (32),
    .UOP_WIDTH  (60),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .fetch_valid_i  (fetch_valid),
    .fetch_ready_o  (fetch_ready),
    .fetch_instr_i  (fetch_instr),
    .fetch_pc_i     (fetch_pc),
    .dec_instr_o    (dec_instr),
    .dec_pc_o       (dec_pc),
    .dec_nop_i      (dec_nop),
    .dec_invalid_i  (dec_invalid),
    .dec_uop_i      (dec_uop),
    .uop_valid_o    (uop_valid),
    .uop_ready_i    (uop_ready),
    .uop_out_o      (uop_out),
    .illegal_valid_o(illegal_valid),
    .illegal_pc_o   (illegal_pc),
    .nop_drop_o     (nop_drop),
    .fifo_count_o   (fifo_count)
  );

  function automatic logic [59:0] mk_uop(input logic [31:0] instr, input logic [31:0] pc);
    return {instr[27:0], pc};
  endfunction

  // Stub decoder
  assign dec_nop     = (dec_instr == Nop);
  assign dec_invalid = (dec_instr == Ill);
  assign dec_uop     = mk_uop(dec_instr, dec_pc);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input bit emits);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_pc    = pc;
    if (emits) expq.push_back(mk_uop(instr, pc));
  endtask

  always @(negedge clk) begin
    if (uop_valid && uop_ready) begin
      uop_cnt++;
      if (expq.size() == 0) begin
        total++;
        $error("FAIL uop_unexpected observed=%0h expected=none", uop_out);
      end else begin
        chk("uop_out", 64'(uop_out), 64'(expq.pop_front()));
      end
    end
    if (nop_drop) nop_cnt++;
    if (illegal_valid) begin
      ill_cnt++;
      ill_pc_seen = illegal_pc;
    end
  end

  initial begin
    int u0, n0, i0;
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    uop_ready = 1'b0;
    #3;
    chk("rst_uop_valid", 64'(uop_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_illegal_valid", 64'(illegal_valid), 64'd0);
    chk("rst_nop_drop", 64'(nop_drop), 64'd0);
    chk("rst_uop_out", 64'(uop_out), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single instruction stream
    uop_ready = 1'b1;
    offer(Add, 32'h100, 1'b1);
    tick();
    fetch_valid = 1'b0;
    chk("stream_count_n1", 64'(fifo_count), 64'd1);
    chk("stream_valid_n1", 64'(uop_valid), 64'd0);
    tick();
    chk("stream_valid_n2", 64'(uop_valid), 64'd1);
    chk("stream_pc_field", 64'(uop_out[31:0]), 64'h100);
    chk("stream_count_n2", 64'(fifo_count), 64'd0);
    tick();
    chk("stream_valid_n3", 64'(uop_valid), 64'd0);

    // NOP drop
    u0 = uop_cnt; n0 = nop_cnt;
    offer(Nop, 32'h100, 1'b0);
    tick();
    offer(Add, 32'h104, 1'b1);
    tick();
    fetch_valid = 1'b0;
    repeat (4) tick();
    chk("nop_pulses", 64'(nop_cnt - n0), 64'd1);
    chk("nop_uops", 64'(uop_cnt - u0), 64'd1);

    // Backpressure until full
    uop_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(Add + (32'(i) << 7), 32'h300 + 32'(i) * 4, i < 5);
      #1;
      chk("bp_fetch_ready", 64'(fetch_ready), (i < 5) ? 64'd1 : 64'd0);
      tick();
    end
    fetch_valid = 1'b0;
    chk("bp_count_full", 64'(fifo_count), 64'd4);
    chk("bp_fetch_ready_full", 64'(fetch_ready), 64'd0);
    repeat (3) tick();
    chk("bp_uop_valid", 64'(uop_valid), 64'd1);
    chk("bp_uop_stable", 64'(uop_out), 64'(mk_uop(Add, 32'h300)));
    u0 = uop_cnt;
    uop_ready = 1'b1;
    repeat (5) tick();
    chk("bp_drain_rate", 64'(uop_cnt - u0), 64'd5);
    chk("bp_drain_count", 64'(fifo_count), 64'd0);
    chk("bp_drain_valid", 64'(uop_valid), 64'd0);
    chk("bp_drain_queue", 64'(expq.size()), 64'd0);

    // Illegal instruction halts until flush
    u0 = uop_cnt; i0 = ill_cnt;
    offer(Ill, 32'h200, 1'b0);
    tick();
    offer(Add, 32'h204, 1'b0);
    tick();
    offer(Add + 32'h80, 32'h208, 1'b0);
    tick();
    fetch_valid = 1'b0;
    repeat (4) tick();
    chk("ill_pulses", 64'(ill_cnt - i0), 64'd1);
    chk("ill_pc", 64'(ill_pc_seen), 64'h200);
    chk("ill_count_held", 64'(fifo_count), 64'd2);
    chk("ill_no_uops", 64'(uop_cnt - u0), 64'd0);
    chk("ill_head_pc", 64'(dec_pc), 64'h204);
    flush = 1'b1;
    #1;
    chk("flush_fetch_ready", 64'(fetch_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_count", 64'(fifo_count), 64'd0);
    offer(Add, 32'h400, 1'b1);
    tick();
    fetch_valid = 1'b0;
    tick();
    chk("post_flush_valid", 64'(uop_valid), 64'd1);
    chk("post_flush_pc", 64'(uop_out[31:0]), 64'h400);
    tick();

    // Flush racing a push with a held uop
    uop_ready = 1'b0;
    offer(Add, 32'h500, 1'b0);
    tick();
    fetch_valid = 1'b0;
    tick();
    chk("race_held_valid", 64'(uop_valid), 64'd1);
    flush = 1'b1;
    offer(Add, 32'h504, 1'b0);
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("race_count", 64'(fifo_count), 64'd0);
    chk("race_valid", 64'(uop_valid), 64'd0);
    tick();
    chk("race_not_stored", 64'(fifo_count), 64'd0);
    chk("race_valid_later", 64'(uop_valid), 64'd0);
    uop_ready = 1'b1;

    // Asynchronous reset mid-stream; also leaves a prior illegal_pc to clear
    i0 = ill_cnt;
    offer(Ill, 32'h240, 1'b0);
    tick();
    fetch_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(Add, 32'h600, 1'b0);
    tick();
    offer(Add, 32'h604, 1'b0);
    tick();
    fetch_valid = 1'b0;
    chk("arst_pre_valid", 64'(uop_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_uop_valid", 64'(uop_valid), 64'd0);
    chk("arst_fifo_count", 64'(fifo_count), 64'd0);
    chk("arst_uop_out", 64'(uop_out), 64'd0);
    chk("arst_illegal_pc", 64'(illegal_pc), 64'd0);
    chk("arst_illegal_valid", 64'(illegal_valid), 64'd0);
    chk("arst_nop_drop", 64'(nop_drop), 64'd0);
    repeat (2) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst_no_partial", 64'(uop_valid), 64'd0);
    offer(Add, 32'h700, 1'b1);
    tick();
    fetch_valid = 1'b0;
    chk("arst_n1_valid", 64'(uop_valid), 64'd0);
    tick();
    chk("arst_n2_valid", 64'(uop_valid), 64'd1);
    chk("arst_n2_pc", 64'(uop_out[31:0]), 64'h700);
    tick();
    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    chk("ill_pulse_before_rst", 64'(ill_cnt - i0), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Sequences the combinational decode stage between fetch and dispatch.
- Buffers fetched instructions in a small FIFO and presents the FIFO head to the decoder.
- Registers the resulting uop behind a valid/ready handshake, silently drops decoded NOPs, and halts on an illegal instruction until a pipeline flush.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- PC_WIDTH, 32, program counter width (matches pc_t).
- UOP_WIDTH, 60, packed uop_t width.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline redirect; discards all buffered state.
- fetch_valid  in  1  fetch offers an instruction.
- fetch_ready  out  1  buffer can accept.
- fetch_instr  in  INSTR_WIDTH  instruction word.
- fetch_pc  in  PC_WIDTH  instruction PC.
- dec_instr  out  INSTR_WIDTH  FIFO head instruction to decoder.
- dec_pc  out  PC_WIDTH  FIFO head PC to decoder.
- dec_nop  in  1  decoder: head is architectural NOP.
- dec_invalid  in  1  decoder: head opcode illegal.
- dec_uop  in  UOP_WIDTH  decoder uop for head.
- uop_valid  out  1  registered uop available.
- uop_ready  in  1  dispatch accepts uop.
- uop_out  out  UOP_WIDTH  registered uop.
- illegal_valid  out  1  one-cycle illegal-instruction trap pulse.
- illegal_pc  out  PC_WIDTH  PC of the illegal instruction.
- nop_drop  out  1  one-cycle pulse per discarded NOP.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count = 0.
  - uop_valid, illegal_valid and nop_drop = 0.
  - uop_out and illegal_pc = 0.
  - State = RUN.
- FIFO:
  - fetch_ready = (fifo_count < FIFO_DEPTH) && !flush. Registered-full only; a same-cycle pop does not raise fetch_ready.
  - push = fetch_valid && fetch_ready.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Decoder feed: dec_instr and dec_pc always drive the FIFO head. When empty they are don't-care, and dec_* inputs are ignored.
- States:
  - RUN: normal operation.
  - HALT: entered when the head decodes illegal. No pops; fetch still fills until full. Left only on flush (-> RUN).
- Consume (RUN only): consume = (fifo_count != 0) && (!uop_valid || uop_ready).
- On consume, the head is popped, and dec_invalid, dec_nop and normal are evaluated in that priority order:
  - dec_invalid: no uop loaded; next cycle illegal_valid = 1 and illegal_pc = head PC; state -> HALT.
  - dec_nop: no uop loaded; nop_drop = 1 next cycle.
  - Otherwise: uop_out <= dec_uop; uop_valid <= 1.
- Output register:
  - If uop_valid && uop_ready and no new load this cycle, uop_valid <= 0.
  - uop_out holds while uop_valid && !uop_ready (stable under backpressure).
- Latency: an instruction pushed in cycle N is at the head in N+1, and its uop_valid is high in N+2 at the earliest. Sustained throughput is 1 uop/cycle with uop_ready held high.
- illegal_valid and nop_drop are single-cycle pulses, otherwise 0.
- flush has highest priority, effective on the next edge:
  - FIFO emptied (pointers 0, count 0).
  - uop_valid = 0, illegal_valid = 0, nop_drop = 0.
  - State = RUN.
  - Push and consume in the flush cycle are suppressed.
- Reset mid-operation: all state is immediately returned to reset values. No partial uop is emitted after rst_n rises.
- Invariant: fifo_count never exceeds FIFO_DEPTH or underflows. An assertion in simulation flags any violation.

Test Plan:
- Stream: push ADD x1,x2,x3 (0x003100B3) at PC 0x100 with uop_ready=1 -> uop_valid high 2 cycles later, uop_out PC field 0x100; fifo_count returns to 0.
- NOP drop: push ADDI x0,x0,0 (0x00000013) then ADD at 0x104 -> nop_drop pulses once; only one uop emitted, with PC 0x104.
- Backpressure/full: FIFO_DEPTH=4, uop_ready=0, push 6 instructions -> one uop held stable, fifo_count=4, fetch_ready=0; releasing uop_ready drains all 5 in order at 1/cycle.
- Illegal: push 0xFFFFFFFF at PC 0x200 followed by 2 valid instrs -> illegal_valid single pulse with illegal_pc=0x200; no further uops; fifo_count=2 held; flush -> fifo_count=0, state RUN, next push decodes normally.
- Flush race: assert flush in the same cycle as fetch_valid=1 with uop_valid=1 -> next cycle fifo_count=0, uop_valid=0, pushed instruction not stored.
- Async reset: drop rst_n mid-stream between clock edges -> all outputs 0 immediately; after release, first push yields uop 2 cycles later.
